mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported, fixed-latency unified memory between the instruction-fetch (IF)
//  and data-memory (DM) requesters of the processor core.
//  - Fixed priority: DM first; IF is protected from starvation.
//  - One outstanding transaction at a time.
//  - Returns a one-cycle response pulse to the winning requester.
//  - Sits between the core's fetch/mem stages and the memory macro inside ProcessorTop.
// PARAMETERS
//  ADDR_W      32  address width, both requesters and memory
//  DATA_W      32  data width; byte enables are DATA_W/8 bits
//  MEM_LAT     2   cycles from mem_en to valid mem_rdata (legal range 1..15)
//  STARVE_MAX  4   consecutive IF losses before IF is forced to win once (1..15)
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         asynchronous, active-low reset
//  if_req     in   1         IF read request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W    IF read address
//  if_gnt     out  1         IF request accepted this cycle
//  if_rvalid  out  1         IF read data valid (one-cycle pulse)
//  if_rdata   out  DATA_W    IF read data
//  dm_req     in   1         DM request; held with dm_* until dm_gnt
//  dm_we      in   1         1 = write, 0 = read
//  dm_addr    in   ADDR_W    DM address
//  dm_wdata   in   DATA_W    DM write data
//  dm_be      in   DATA_W/8  DM byte enables
//  dm_gnt     out  1         DM request accepted this cycle
//  dm_rvalid  out  1         DM completion pulse (reads and writes)
//  dm_rdata   out  DATA_W    DM read data; 0 for writes
//  mem_en     out  1         memory access strobe
//  mem_we     out  1         memory write enable
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_be     out  DATA_W/8  memory byte enables (all-ones for IF)
//  mem_rdata  in   DATA_W    memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): FSM = IDLE, latency counter = 0, starve counter = 0.
//    All outputs are 0. Any outstanding transaction is dropped and no rvalid is issued.
//  - FSM states: IDLE, WAIT, RESP.
//    - IDLE --grant--> WAIT when MEM_LAT > 1; IDLE --grant--> RESP when MEM_LAT = 1.
//    - WAIT: counts MEM_LAT-1 cycles, then moves to RESP.
//    - RESP: asserts rvalid of the owner; rdata = mem_rdata (combinational pass-through).
//      RESP --grant--> WAIT/RESP (back-to-back), otherwise RESP -> IDLE.
//  - Arbitration runs only in IDLE and RESP.
//    - gnt and mem_* are combinational in the same cycle as the req.
//    - Owner and dm_we are registered on grant.
//  - Latency: grant in cycle t -> rvalid in cycle t+MEM_LAT. Peak throughput is 1 txn per MEM_LAT cycles.
//  - Priority:
//    - Both requesting: DM wins unless the starve counter equals STARVE_MAX, in which case IF wins.
//    - Starve counter increments when IF requests and loses; clears on IF grant or when if_req=0.
//      It saturates at STARVE_MAX.
//  - Simultaneous response and new request: the RESP pulse goes to the old owner and the new
//    grant is issued in the same cycle. Both are legal and required.
//  - A req deasserted before gnt is a protocol error; the arbiter ignores it (no sticky request).
//  - mem_* outputs are 0 whenever mem_en = 0.
// CONFIGURATION
//  - MEM_ARB_PERF_CNT_EN defined: adds outputs perf_if_stall[31:0] and perf_dm_stall[31:0].
//    Each counts cycles its req=1 and gnt=0; saturates at all-ones; cleared by reset.
//  - Undefined: these ports and counters do not exist; arbitration behaviour is identical.
// STRUCTURE
//  - Package mem_arb_pkg: state typedef (IDLE/WAIT/RESP), owner typedef (OWN_IF/OWN_DM),
//    CNT_W = 4 counter width constant.
//  - Sub-module mem_arb_lat_timer: loadable down-counter.
//    Loads MEM_LAT-1 on grant; flags done at 0. Reused for the WAIT state.
// TESTING
//  1. Reset mid-WAIT: DM read granted, reset pulled low next cycle -> no dm_rvalid; all outputs 0; FSM IDLE.
//  2. IF only, MEM_LAT=2: if_addr=0x10 at t -> if_gnt@t, mem_en@t, if_rvalid@t+2 with mem_rdata.
//  3. Both requesting continuously, STARVE_MAX=4 -> grant sequence DM,DM,DM,DM,IF, repeating.
//  4. DM write 0xDEADBEEF, be=4'b0011 -> mem_we=1, mem_be=4'b0011; dm_rvalid pulse with dm_rdata=0.
//  5. Back-to-back: IF held high through RESP -> new if_gnt in the same cycle as the prior if_rvalid.
//  6. With MEM_ARB_PERF_CNT_EN defined: DM blocks IF for 3 cycles -> perf_if_stall=3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the IF/DM unified-memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WAIT, RESP)
//   owner_t     : which requester owns the outstanding transaction
//   CNT_W       : width of the latency and starvation counters (MEM_LAT, STARVE_MAX <= 15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_lat_timer.sv
// mem_arb_lat_timer
//   Loadable down-counter that times the memory latency while the arbiter waits.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous, active-low reset (count cleared to 0)
//     load   in   grant strobe; loads MEM_LAT-1
//     dec    in   decrement enable (arbiter in WAIT)
//     done   out  count is landing on 0 this cycle: last WAIT cycle
module mem_arb_lat_timer
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // The arbiter leaves WAIT on the edge where the count reaches 0, so the
  // flag is raised while the count still reads 1.
  assign done = (cnt <= CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the instruction-fetch (IF)
//   and data-memory (DM) requesters. DM has fixed priority; IF is forced to win once
//   after STARVE_MAX consecutive losses. One transaction outstanding at a time; the
//   owner receives a one-cycle rvalid pulse MEM_LAT cycles after its grant.
//   Optional build macro: MEM_ARB_PERF_CNT_EN adds saturating stall counters.
//   Ports:
//     clk, reset                       clock, asynchronous active-low reset
//     if_req/if_addr -> if_gnt         IF read request / same-cycle grant
//     if_rvalid, if_rdata              IF response pulse and read data
//     dm_req/dm_we/dm_addr/dm_wdata/dm_be -> dm_gnt   DM request / grant
//     dm_rvalid, dm_rdata              DM completion pulse; rdata is 0 for writes
//     mem_en/we/addr/wdata/be          memory strobe and command (all 0 when idle)
//     mem_rdata                        memory read data, MEM_LAT cycles after mem_en
//     perf_if_stall, perf_dm_stall     (MEM_ARB_PERF_CNT_EN only) req-without-gnt cycles
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]         perf_if_stall,
  output logic [31:0]         perf_dm_stall
`endif
);

  localparam arb_state_t       GNT_STATE = (MEM_LAT > 1) ? WAIT : RESP;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  function automatic logic [CNT_W-1:0] starve_inc(input logic [CNT_W-1:0] c);
    return (c >= STARVE_LIM) ? c : c + 1'b1;
  endfunction

  arb_state_t       state;
  owner_t           owner_p1;
  logic             dm_we_p1;
  logic [CNT_W-1:0] starve;

  logic arb_en;
  logic if_win;
  logic dm_win;
  logic grant;
  logic rsp;
  logic tmr_done;

  // ---- stage 0: arbitration and memory command (combinational with req) ----
  // Reset gates the arbiter so every output is 0 while reset is held.
  assign arb_en = reset && ((state == IDLE) || (state == RESP));
  assign if_win = arb_en && if_req && (!dm_req || (starve == STARVE_LIM));
  assign dm_win = arb_en && dm_req && !if_win;
  assign grant  = if_win || dm_win;

  always_comb begin
    if_gnt    = if_win;
    dm_gnt    = dm_win;
    mem_en    = grant;
    mem_we    = dm_win && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (dm_win) begin
      mem_addr = dm_addr;
      mem_be   = dm_be;
      if (dm_we) begin
        mem_wdata = dm_wdata;
      end
    end else if (if_win) begin
      mem_addr = if_addr;
      mem_be   = '1;
    end
  end

  mem_arb_lat_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_timer (
    .clk   (clk),
    .reset (reset),
    .load  (grant),
    .dec   (state == WAIT),
    .done  (tmr_done)
  );

  // ---- stage 1: transaction ownership, FSM and starvation tracking ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner_p1 <= OWN_IF;
      dm_we_p1 <= 1'b0;
      starve   <= '0;
    end else begin
      case (state)
        IDLE:    if (grant) state <= GNT_STATE;
        WAIT:    if (tmr_done) state <= RESP;
        RESP:    state <= grant ? GNT_STATE : IDLE;
        default: state <= IDLE;
      endcase

      if (grant) begin
        owner_p1 <= dm_win ? OWN_DM : OWN_IF;
        dm_we_p1 <= dm_win && dm_we;
      end

      // Only arbitration cycles count as a loss; waiting behind an
      // outstanding transaction does not.
      if (!if_req || if_win) begin
        starve <= '0;
      end else if (dm_win) begin
        starve <= starve_inc(starve);
      end
    end
  end

  // ---- stage 2: response to the owner, read data passed straight through ----
  assign rsp       = (state == RESP);
  assign if_rvalid = rsp && (owner_p1 == OWN_IF);
  assign dm_rvalid = rsp && (owner_p1 == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = (dm_rvalid && !dm_we_p1) ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_stall <= '0;
      perf_dm_stall <= '0;
    end else begin
      if (if_req && !if_gnt) perf_if_stall <= sat_inc32(perf_if_stall);
      if (dm_req && !dm_gnt) perf_dm_stall <= sat_inc32(perf_dm_stall);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4). The memory is a
//   two-cycle pipe returning addr ^ 0xA5A50000 for each strobed access.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall;
  logic [31:0] perf_dm_stall;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .MEM_LAT    (2),
    .STARVE_MAX (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_be     (dm_be),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_if_stall (perf_if_stall),
    .perf_dm_stall (perf_dm_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_d1 = '0;
  logic [31:0] mem_d2 = '0;
  always @(posedge clk) begin
    mem_d1 <= mem_en ? (mem_addr ^ 32'hA5A5_0000) : 32'h0;
    mem_d2 <= mem_d1;
  end
  assign mem_rdata = mem_d2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input logic req, input logic [31:0] addr);
    if_req  = req;
    if_addr = addr;
  endtask

  task automatic drive_dm(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    dm_req   = req;
    dm_we    = we;
    dm_addr  = addr;
    dm_wdata = wdata;
    dm_be    = be;
  endtask

  initial begin
    reset = 1'b0;
    drive_if(1'b1, 32'h4);
    drive_dm(1'b1, 1'b1, 32'h8, 32'h1234_5678, 4'hF);
    #2;
    // requests during reset must not reach the outputs
    check("rst_if_gnt",    32'(if_gnt),    32'h0);
    check("rst_dm_gnt",    32'(dm_gnt),    32'h0);
    check("rst_mem_en",    32'(mem_en),    32'h0);
    check("rst_mem_we",    32'(mem_we),    32'h0);
    check("rst_mem_addr",  mem_addr,       32'h0);
    check("rst_mem_wdata", mem_wdata,      32'h0);
    check("rst_mem_be",    32'(mem_be),    32'h0);
    check("rst_rvalid",    32'({if_rvalid, dm_rvalid}), 32'h0);
    drive_if(1'b0, 32'h0);
    drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // IF-only read at 0x10
    drive_if(1'b1, 32'h10);
    #1;
    check("if_gnt",      32'(if_gnt),  32'h1);
    check("if_mem_en",   32'(mem_en),  32'h1);
    check("if_mem_addr", mem_addr,     32'h10);
    check("if_mem_be",   32'(mem_be),  32'hF);
    check("if_mem_we",   32'(mem_we),  32'h0);
    check("if_dm_gnt",   32'(dm_gnt),  32'h0);
    tick();
    drive_if(1'b0, 32'h0);
    #1;
    check("if_wait_rvalid", 32'(if_rvalid), 32'h0);
    check("if_wait_mem_en", 32'(mem_en),    32'h0);
    tick();
    #1;
    check("if_rvalid",       32'(if_rvalid), 32'h1);
    check("if_rdata",        if_rdata,       32'hA5A5_0010);
    check("if_rsp_dm_rvld",  32'(dm_rvalid), 32'h0);
    tick();
    #1;
    check("if_idle_rvalid",  32'(if_rvalid), 32'h0);

    // DM write, partial byte enables
    drive_dm(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011);
    #1;
    check("wr_dm_gnt",    32'(dm_gnt),  32'h1);
    check("wr_mem_we",    32'(mem_we),  32'h1);
    check("wr_mem_be",    32'(mem_be),  32'h3);
    check("wr_mem_wdata", mem_wdata,    32'hDEAD_BEEF);
    check("wr_mem_addr",  mem_addr,     32'h20);
    tick();
    drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("wr_wait_rvalid", 32'(dm_rvalid), 32'h0);
    check("wr_wait_wdata",  mem_wdata,      32'h0);
    tick();
    #1;
    check("wr_rvalid", 32'(dm_rvalid), 32'h1);
    check("wr_rdata",  dm_rdata,       32'h0);
    tick();
    #1;
    check("wr_idle_rvalid", 32'(dm_rvalid), 32'h0);

    // back-to-back IF: new grant in the cycle of the previous response
    drive_if(1'b1, 32'h30);
    #1;
    check("b2b_gnt0", 32'(if_gnt), 32'h1);
    tick();
    drive_if(1'b1, 32'h34);
    #1;
    check("b2b_wait_gnt", 32'(if_gnt), 32'h0);
    tick();
    #1;
    check("b2b_rvalid0", 32'(if_rvalid), 32'h1);
    check("b2b_rdata0",  if_rdata,       32'hA5A5_0030);
    check("b2b_gnt1",    32'(if_gnt),    32'h1);
    check("b2b_addr1",   mem_addr,       32'h34);
    tick();
    drive_if(1'b0, 32'h0);
    #1;
    tick();
    #1;
    check("b2b_rvalid1", 32'(if_rvalid), 32'h1);
    check("b2b_rdata1",  if_rdata,       32'hA5A5_0034);
    tick();

    // both requesting continuously: DM,DM,DM,DM,IF,DM
    drive_if(1'b1, 32'h50);
    drive_dm(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("stv_if_gnt%0d", i),    32'(if_gnt),    32'(i == 4));
      check($sformatf("stv_dm_gnt%0d", i),    32'(dm_gnt),    32'(i != 4));
      check($sformatf("stv_dm_rvld%0d", i),   32'(dm_rvalid), 32'(i >= 1 && i <= 4));
      check($sformatf("stv_if_rvld%0d", i),   32'(if_rvalid), 32'(i == 5));
      check($sformatf("stv_dm_rdata%0d", i),  dm_rdata, (i >= 1 && i <= 4) ? 32'hA5A5_0040 : 32'h0);
      check($sformatf("stv_if_rdata%0d", i),  if_rdata, (i == 5) ? 32'hA5A5_0050 : 32'h0);
      tick();
      tick();
    end
    drive_if(1'b0, 32'h0);
    drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("stv_last_rvalid", 32'(dm_rvalid), 32'h1);
    check("stv_last_rdata",  dm_rdata,       32'hA5A5_0040);
    check("stv_last_gnt",    32'(dm_gnt),    32'h0);
    tick();

    // reset pulled in WAIT: transaction dropped, no response
    drive_dm(1'b1, 1'b0, 32'h60, 32'h0, 4'hF);
    #1;
    check("rw_dm_gnt", 32'(dm_gnt), 32'h1);
    tick();
    reset = 1'b0;
    #1;
    check("rw_gnt",     32'({if_gnt, dm_gnt}),       32'h0);
    check("rw_mem_en",  32'(mem_en),                 32'h0);
    check("rw_addr",    mem_addr,                    32'h0);
    check("rw_rvalid",  32'({if_rvalid, dm_rvalid}), 32'h0);
    drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    #1;
    check("rw_late_rvalid", 32'(dm_rvalid), 32'h0);
    check("rw_late_rdata",  dm_rdata,       32'h0);
    tick();
    reset = 1'b1;
    tick();

`ifdef MEM_ARB_PERF_CNT_EN
    // DM holds the port; IF waits three cycles
    drive_if(1'b1, 32'h74);
    drive_dm(1'b1, 1'b0, 32'h70, 32'h0, 4'hF);
    #1;
    check("pc_dm_gnt0", 32'(dm_gnt), 32'h1);
    tick();
    tick();
    #1;
    check("pc_dm_gnt1", 32'(dm_gnt), 32'h1);
    tick();
    drive_dm(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    check("pc_if_stall", perf_if_stall, 32'd3);
    check("pc_dm_stall", perf_dm_stall, 32'd1);
    tick();
    #1;
    check("pc_if_gnt", 32'(if_gnt), 32'h1);
    tick();
    drive_if(1'b0, 32'h0);
    tick();
    tick();
`endif

    // normal fetch after reset
    drive_if(1'b1, 32'h80);
    #1;
    check("post_if_gnt", 32'(if_gnt), 32'h1);
    tick();
    drive_if(1'b0, 32'h0);
    tick();
    #1;
    check("post_if_rvalid", 32'(if_rvalid), 32'h1);
    check("post_if_rdata",  if_rdata,       32'hA5A5_0080);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
